// File: rtl/mask_proc_arbiter.sv
// ---------------------------------------------------------------------------
// mask_proc_arbiter
//
// Shares one mask_processor instance between two pixel streams. Grants are
// held for a whole packet (first beat through `last`). Between packets the
// grant rotates round-robin. Each accepted beat is forwarded to the processor
// one cycle later. A {valid, id} tag follows the beat through a shift
// pipeline, and the processor result is steered back to the requester that
// owns it.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req{0,1}_valid/ready     per-requester beat handshake
//   req{0,1}_pixel/mask/op   beat payload
//   req{0,1}_last            final beat of packet, releases the grant
//   proc_valid/pixel/mask/op registered beat to the shared processor
//   proc_out_valid/proc_out  processor result, PROC_LATENCY after proc_valid
//   rsp{0,1}_valid/data      result steered to its owning requester
//   beats{0,1}               saturating count of accepted beats
//   tag_error                sticky: processor valid disagreed with tag pipe
// ---------------------------------------------------------------------------
module mask_proc_arbiter #(
    parameter int DATA_WIDTH      = 8,
    parameter int MASK_WIDTH      = 8,
    parameter int OPERATION_WIDTH = 3,
    parameter int PROC_LATENCY    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [DATA_WIDTH-1:0]      req0_pixel,
    input  logic [MASK_WIDTH-1:0]      req0_mask,
    input  logic [OPERATION_WIDTH-1:0] req0_op,
    input  logic                       req0_last,

    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [DATA_WIDTH-1:0]      req1_pixel,
    input  logic [MASK_WIDTH-1:0]      req1_mask,
    input  logic [OPERATION_WIDTH-1:0] req1_op,
    input  logic                       req1_last,

    output logic                       proc_valid,
    output logic [DATA_WIDTH-1:0]      proc_pixel,
    output logic [MASK_WIDTH-1:0]      proc_mask,
    output logic [OPERATION_WIDTH-1:0] proc_op,
    input  logic                       proc_out_valid,
    input  logic [DATA_WIDTH-1:0]      proc_out,

    output logic                       rsp0_valid,
    output logic [DATA_WIDTH-1:0]      rsp0_data,
    output logic                       rsp1_valid,
    output logic [DATA_WIDTH-1:0]      rsp1_data,

    output logic [CNT_WIDTH-1:0]       beats0,
    output logic [CNT_WIDTH-1:0]       beats1,
    output logic                       tag_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_next;
    logic   rr_ptr, rr_ptr_next;   // preferred requester when both are valid

    logic   acc0, acc1, accept;

    // Tag pipeline: stage 0 is loaded at accept, so the last stage lines up
    // with proc_out_valid (one register stage + PROC_LATENCY processor stages).
    logic [PROC_LATENCY:0] tag_valid;
    logic [PROC_LATENCY:0] tag_id;

    // Ready is a pure decode of the grant state, so it never depends on
    // valid and cannot form a combinational loop with the source.
    assign req0_ready = (state == GRANT0);
    assign req1_ready = (state == GRANT1);

    assign acc0   = req0_valid && req0_ready;
    assign acc1   = req1_valid && req1_ready;
    assign accept = acc0 || acc1;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        unique case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_next = rr_ptr ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                // Valid low holds the grant; only the last beat releases it.
                if (acc0 && req0_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = 1'b1;
                end
            end
            GRANT1: begin
                if (acc1 && req1_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // NOTE: the payload registers are reset too (they are visible outputs with
    // defined reset values); otherwise data-only registers would not need it.
    always_ff @(posedge clk) begin
        if (rst) begin
            proc_valid <= 1'b0;
            proc_pixel <= '0;
            proc_mask  <= '0;
            proc_op    <= '0;
        end else begin
            proc_valid <= accept;
            if (accept) begin
                proc_pixel <= acc1 ? req1_pixel : req0_pixel;
                proc_mask  <= acc1 ? req1_mask  : req0_mask;
                proc_op    <= acc1 ? req1_op    : req0_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[PROC_LATENCY-1:0], accept};
            tag_id    <= {tag_id[PROC_LATENCY-1:0], acc1};
        end
    end

    // A processor result without a matching tag (or a tag without a result)
    // means the two pipelines have slipped; flag it until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_error <= 1'b0;
        end else if (proc_out_valid != tag_valid[PROC_LATENCY]) begin
            tag_error <= 1'b1;
        end
    end

    assign rsp0_valid = proc_out_valid && tag_valid[PROC_LATENCY] && !tag_id[PROC_LATENCY];
    assign rsp1_valid = proc_out_valid && tag_valid[PROC_LATENCY] &&  tag_id[PROC_LATENCY];
    assign rsp0_data  = proc_out;
    assign rsp1_data  = proc_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats0 <= '0;
            beats1 <= '0;
        end else begin
            if (acc0 && (beats0 != {CNT_WIDTH{1'b1}})) begin
                beats0 <= beats0 + 1'b1;
            end
            if (acc1 && (beats1 != {CNT_WIDTH{1'b1}})) begin
                beats1 <= beats1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mask_proc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mask_proc_arbiter
//
// Directed bench for mask_proc_arbiter. A small behavioural processor model
// (2-cycle latency, AND/OR/XOR/PASS) closes the loop; an inject input forces
// a stray proc_out_valid. The DUT uses CNT_WIDTH=4 so the saturation case is
// short; every other case resets first so counts stay small.
// ---------------------------------------------------------------------------
module tb_mask_proc_arbiter;

    localparam int DW = 8;
    localparam int MW = 8;
    localparam int OW = 3;
    localparam int PL = 2;
    localparam int CW = 4;

    localparam logic [OW-1:0] OP_AND  = 3'd0;
    localparam logic [OW-1:0] OP_OR   = 3'd1;
    localparam logic [OW-1:0] OP_XOR  = 3'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_last;
    logic [DW-1:0] req0_pixel;
    logic [MW-1:0] req0_mask;
    logic [OW-1:0] req0_op;
    logic          req1_valid, req1_ready, req1_last;
    logic [DW-1:0] req1_pixel;
    logic [MW-1:0] req1_mask;
    logic [OW-1:0] req1_op;
    logic          proc_valid;
    logic [DW-1:0] proc_pixel;
    logic [MW-1:0] proc_mask;
    logic [OW-1:0] proc_op;
    logic          proc_out_valid;
    logic [DW-1:0] proc_out;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic [CW-1:0] beats0, beats1;
    logic          tag_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mask_proc_arbiter #(
        .DATA_WIDTH(DW), .MASK_WIDTH(MW), .OPERATION_WIDTH(OW),
        .PROC_LATENCY(PL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pixel(req0_pixel),
        .req0_mask(req0_mask), .req0_op(req0_op), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pixel(req1_pixel),
        .req1_mask(req1_mask), .req1_op(req1_op), .req1_last(req1_last),
        .proc_valid(proc_valid), .proc_pixel(proc_pixel), .proc_mask(proc_mask),
        .proc_op(proc_op), .proc_out_valid(proc_out_valid), .proc_out(proc_out),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .beats0(beats0), .beats1(beats1), .tag_error(tag_error)
    );

    // Behavioural processor: result appears PL cycles after proc_valid.
    logic          p1_v, p2_v, inject;
    logic [DW-1:0] p1_d, p2_d;

    function automatic logic [DW-1:0] proc_fn(input logic [DW-1:0] p,
                                              input logic [MW-1:0] m,
                                              input logic [OW-1:0] op);
        case (op)
            OP_AND:  return p & m;
            OP_OR:   return p | m;
            OP_XOR:  return p ^ m;
            default: return p;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
        end else begin
            p1_v <= proc_valid;
            p1_d <= proc_fn(proc_pixel, proc_mask, proc_op);
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
    end

    assign proc_out_valid = p2_v | inject;
    assign proc_out       = p2_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_last = 1'b0; req0_pixel = '0; req0_mask = 8'h0F; req0_op = OP_AND;
        req1_valid = 1'b0; req1_last = 1'b0; req1_pixel = '0; req1_mask = 8'hFF; req1_op = OP_AND;
    endtask

    initial begin
        logic [DW-1:0] pix [4];
        logic [DW-1:0] res [4];
        logic [9:0]    e_rdy0, e_rdy1, e_rsp0, e_rsp1;
        logic [7:0]    g_v0, g_v1, g_l1, g_rdy0, g_rdy1;
        int            n0, n1;
        logic          a0, a1;

        inject = 1'b0;
        idle_inputs();

        // ---------------- Reset with both requesters valid ----------------
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        check("rst_proc_valid", proc_valid, 1'b0);
        check("rst_proc_pixel", proc_pixel, 8'h00);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_beats0", beats0, 4'd0);
        check("rst_tag_error", tag_error, 1'b0);
        rst = 1'b0;
        tick();  // IDLE with both valid, rr_ptr=0 -> GRANT0
        check("first_grant_ready0", req0_ready, 1'b1);
        check("first_grant_ready1", req1_ready, 1'b0);

        // Single-beat packet in the first grant: 0xFF AND 0x0F = 0x0F.
        req1_valid = 1'b0;
        req0_pixel = 8'hFF;
        req0_last  = 1'b1;
        tick();
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        check("single_proc_valid", proc_valid, 1'b1);
        check("single_proc_pixel", proc_pixel, 8'hFF);
        check("single_back_idle", req0_ready, 1'b0);
        check("single_beats0", beats0, 4'd1);
        tick();
        check("single_rsp0_early", rsp0_valid, 1'b0);
        tick();
        check("single_rsp0_valid", rsp0_valid, 1'b1);
        check("single_rsp0_data", rsp0_data, 8'h0F);
        check("single_rsp1_quiet", rsp1_valid, 1'b0);

        // ---------------- Single stream, 4 beats ----------------
        do_reset();
        pix[0] = 8'd10; pix[1] = 8'd20; pix[2] = 8'd30; pix[3] = 8'd40;
        res[0] = 8'd10; res[1] = 8'd4;  res[2] = 8'd14; res[3] = 8'd8;
        req0_valid = 1'b1;
        req0_pixel = pix[0];
        tick();  // grant bubble
        check("ss_ready0", req0_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            req0_valid = (i < 4);
            req0_pixel = (i < 4) ? pix[i] : 8'h00;
            req0_last  = (i == 3);
            tick();
            if (i < 4) begin
                check($sformatf("ss_proc_pixel%0d", i), proc_pixel, pix[i]);
            end
            if (i >= 2) begin
                check($sformatf("ss_rsp0_valid%0d", i - 2), rsp0_valid, 1'b1);
                check($sformatf("ss_rsp0_data%0d", i - 2), rsp0_data, res[i - 2]);
            end
            check($sformatf("ss_rsp1_quiet%0d", i), rsp1_valid, 1'b0);
        end
        check("ss_beats0", beats0, 4'd4);
        check("ss_beats1", beats1, 4'd0);
        tick();
        check("ss_rsp0_done", rsp0_valid, 1'b0);
        check("ss_tag_error", tag_error, 1'b0);

        // ---------------- Contention, 3-beat packets ----------------
        do_reset();
        idle_inputs();
        e_rdy0 = 10'b10_0000_1110;  // c1..c3, c9
        e_rdy1 = 10'b00_1110_0000;  // c5..c7
        e_rsp0 = 10'b00_0111_0000;  // req0 beats accepted c1..c3
        e_rsp1 = 10'b11_0000_0000;  // req1 beats accepted c5.. -> c8, c9
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 10; c++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_last  = (n0 == 2);
            req1_last  = (n1 == 2);
            req0_pixel = 8'h10 + 8'(n0);
            req1_pixel = 8'h40 + 8'(n1);
            check($sformatf("ct_ready0_c%0d", c), req0_ready, e_rdy0[c]);
            check($sformatf("ct_ready1_c%0d", c), req1_ready, e_rdy1[c]);
            check($sformatf("ct_rsp0_c%0d", c), rsp0_valid, e_rsp0[c]);
            check($sformatf("ct_rsp1_c%0d", c), rsp1_valid, e_rsp1[c]);
            if (c == 8) begin
                check("ct_rsp1_data_first", rsp1_data, 8'h40);
            end
            a0 = req0_ready;
            a1 = req1_ready;
            tick();
            if (a0) n0 = (n0 == 2) ? 0 : n0 + 1;
            if (a1) n1 = (n1 == 2) ? 0 : n1 + 1;
        end
        check("ct_beats0", beats0, 4'd4);
        check("ct_beats1", beats1, 4'd3);
        check("ct_tag_error", tag_error, 1'b0);

        // ---------------- Gap inside req1 packet ----------------
        do_reset();
        idle_inputs();
        g_v1   = 8'b0010_0111;
        g_l1   = 8'b0010_0000;
        g_v0   = 8'b1111_1110;
        g_rdy1 = 8'b0011_1110;
        g_rdy0 = 8'b1000_0000;
        for (int c = 0; c < 8; c++) begin
            req0_valid = g_v0[c];
            req1_valid = g_v1[c];
            req1_last  = g_l1[c];
            req1_pixel = 8'h80 + 8'(c);
            check($sformatf("gap_ready0_c%0d", c), req0_ready, g_rdy0[c]);
            check($sformatf("gap_ready1_c%0d", c), req1_ready, g_rdy1[c]);
            tick();
        end
        check("gap_beats1", beats1, 4'd3);

        // ---------------- Stray processor result ----------------
        do_reset();
        idle_inputs();
        inject = 1'b1;
        #1;
        check("tag_rsp0_quiet", rsp0_valid, 1'b0);
        check("tag_rsp1_quiet", rsp1_valid, 1'b0);
        check("tag_error_before", tag_error, 1'b0);
        tick();
        inject = 1'b0;
        check("tag_error_set", tag_error, 1'b1);
        tick();
        tick();
        check("tag_error_sticky", tag_error, 1'b1);

        // ---------------- Saturation (CNT_WIDTH=4) ----------------
        do_reset();
        check("sat_error_cleared", tag_error, 1'b0);
        req0_valid = 1'b1;
        tick();  // grant bubble
        for (int i = 0; i < 20; i++) begin
            req0_last  = (i == 19);
            req0_pixel = 8'(i);
            tick();
            if (i == 14) begin
                check("sat_beats0_at15", beats0, 4'd15);
            end
        end
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        check("sat_beats0", beats0, 4'd15);
        check("sat_beats1", beats1, 4'd0);
        check("sat_idle", req0_ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
